ddr_deser_align: RTL and testbench
==================================

// Module: ddr_deser_align
// PURPOSE
//  Multi-channel DDR input deserialiser with word alignment. Takes per-channel rising/falling
//  sample pairs from DDR input capture cells (already in CLK domain), shifts 2 bits/clock
//  into WIDTH-bit words, hunts for SYNC_PATTERN at any bit offset and locks word framing.
//  Sits between the DDR capture primitives and the per-channel receive FIFOs/decoders.
// PARAMETERS
//  CHANNELS      1      number of independent input channels (1..16)
//  WIDTH         8      word width in bits; even, 4..32
//  SYNC_PATTERN  8'hA5  alignment word (WIDTH bits), MSB received first
//  SYNC_COUNT    4      consecutive word-boundary SYNC matches required to lock (1..15)
// PORTS
//  CLK          in   1               capture clock; all logic on rising edge
//  RST_N        in   1               asynchronous reset, active low
//  ENABLE       in   1               0: all channels held in IDLE
//  RESYNC       in   CHANNELS        1-cycle pulse per channel: drop lock, return to HUNT
//  Q1           in   CHANNELS        rising-edge sample per channel (earlier bit)
//  Q2           in   CHANNELS        falling-edge sample per channel (later bit)
//  DATA         out  CHANNELS*WIDTH  aligned word, channel n at [n*WIDTH +: WIDTH]
//  DATA_VALID   out  CHANNELS        1-cycle strobe: DATA slice of channel n updated
//  LOCKED       out  CHANNELS        channel in LOCKED state
//  FAIL_CNT     out  CHANNELS*8      per-channel VERIFY failures, saturating at 255
// BEHAVIOUR
//  - Reset (RST_N=0, async): shift regs, DATA, DATA_VALID, LOCKED, FAIL_CNT = 0; state IDLE.
//  - Per channel, every clock: SR[WIDTH:0] <= {SR[WIDTH-2:0], Q1, Q2} (Q1 older than Q2).
//  - Candidates: C0 = SR[WIDTH-1:0], C1 = SR[WIDTH:1]. Selected word W = OFF ? C1 : C0.
//  - Boundary counter BC counts 0..WIDTH/2-1, wraps; boundary = cycle where BC == WIDTH/2-1.
//  - FSM per channel: IDLE, HUNT, VERIFY, LOCKED.
//    IDLE:   ENABLE=1 -> HUNT. Outputs quiet.
//    HUNT:   each clock test C0 then C1 vs SYNC_PATTERN; on match latch OFF (0 priority if
//            both match), set BC=0 so next boundary is WIDTH/2 clocks later, MATCH=1 -> VERIFY
//            (or LOCKED directly when SYNC_COUNT==1).
//    VERIFY: at each boundary: W==SYNC -> MATCH+1; MATCH reaches SYNC_COUNT -> LOCKED.
//            W!=SYNC -> HUNT, FAIL_CNT+1 (saturate 255).
//    LOCKED: at each boundary DATA slice <= W, DATA_VALID=1 next cycle (1 cycle registered
//            latency after the clock whose Q1/Q2 carry the word's last two bits). SYNC words
//            are delivered like data; no automatic lock loss.
//  - RESYNC[n]=1 in any state except IDLE -> HUNT next cycle; LOCKED[n]=0, DATA_VALID[n]=0,
//    DATA slice retained, FAIL_CNT unchanged. RESYNC and boundary same cycle: RESYNC wins.
//  - ENABLE=0 -> all channels IDLE next cycle, LOCKED=0, DATA_VALID=0; SR keeps shifting.
//  - LOCKED is registered; asserts same cycle as first DATA_VALID-eligible boundary window.
//  - Channels fully independent; no cross-channel alignment.
//  - DATA_VALID never asserted outside LOCKED; at most once per WIDTH/2 clocks per channel.
// TESTING
//  1 WIDTH=8, SYNC=A5, SYNC_COUNT=4: stream A5 x4 then 3C, 7E at even offset -> LOCKED after
//    4th A5 boundary, DATA=3C then 7E, DATA_VALID exactly every 4 clocks, FAIL_CNT=0.
//  2 Same stream delayed by 1 bit (odd offset) -> OFF=1, identical DATA sequence 3C, 7E.
//  3 A5 x2 then 00 -> VERIFY fails, FAIL_CNT=1, back to HUNT; then A5 x4 -> LOCKED.
//  4 Locked channel, RESYNC pulse coincident with boundary -> no DATA_VALID, LOCKED=0 next
//    cycle, relock after 4 further A5 words; other channel (CHANNELS=2) unaffected.
//  5 Assert RST_N=0 mid-word while LOCKED -> all outputs 0 immediately (async); ENABLE=0 ->
//    IDLE, no DATA_VALID until ENABLE=1 and relock.
//  6 300 forced VERIFY failures -> FAIL_CNT saturates at 255, no wrap.

Source files
------------

// File: rtl/ddr_deser_align_if.sv
// ddr_deser_align_if: bus bundle for the multi-channel DDR deserialiser.
//   ENABLE      global enable (0 holds every channel idle)
//   RESYNC      per-channel pulse: drop lock and hunt again
//   Q1 / Q2     per-channel rising (earlier) / falling (later) sample
//   DATA        aligned words, channel n at [n*WIDTH +: WIDTH]
//   DATA_VALID  per-channel one-cycle strobe for its DATA slice
//   LOCKED      per-channel word framing locked
//   FAIL_CNT    per-channel saturating verify-failure count, 8 bits each
// master drives ENABLE/RESYNC/Q1/Q2; slave (the deserialiser) drives the rest.
interface ddr_deser_align_if #(
  parameter int unsigned CHANNELS = 1,
  parameter int unsigned WIDTH    = 8
);
  logic                        ENABLE;
  logic [CHANNELS-1:0]         RESYNC;
  logic [CHANNELS-1:0]         Q1;
  logic [CHANNELS-1:0]         Q2;
  logic [CHANNELS*WIDTH-1:0]   DATA;
  logic [CHANNELS-1:0]         DATA_VALID;
  logic [CHANNELS-1:0]         LOCKED;
  logic [CHANNELS*8-1:0]       FAIL_CNT;

  modport master (
    output ENABLE, RESYNC, Q1, Q2,
    input  DATA, DATA_VALID, LOCKED, FAIL_CNT
  );

  modport slave (
    input  ENABLE, RESYNC, Q1, Q2,
    output DATA, DATA_VALID, LOCKED, FAIL_CNT
  );
endinterface

// File: rtl/ddr_deser_align.sv
// ddr_deser_align: multi-channel DDR input deserialiser with word alignment.
// Each channel shifts its Q1/Q2 pair (Q1 older) into a WIDTH+1 bit shift
// register, hunts for SYNC_PATTERN at either an even (C0) or odd (C1) bit
// offset, verifies SYNC_COUNT consecutive framed SYNC words, then delivers
// one aligned word every WIDTH/2 clocks.
// Ports:
//   CLK    capture clock, rising edge
//   RST_N  asynchronous active-low reset
//   bus    ddr_deser_align_if.slave (ENABLE, RESYNC, Q1, Q2 in;
//          DATA, DATA_VALID, LOCKED, FAIL_CNT out)
module ddr_deser_align #(
  parameter int unsigned      CHANNELS     = 1,
  parameter int unsigned      WIDTH        = 8,
  parameter logic [WIDTH-1:0] SYNC_PATTERN = 8'hA5,
  parameter int unsigned      SYNC_COUNT   = 4
) (
  input logic               CLK,
  input logic               RST_N,
  ddr_deser_align_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HUNT,
    S_VERIFY,
    S_LOCKED
  } state_e;

  localparam int unsigned      HALF       = WIDTH / 2;
  localparam int unsigned      BCW        = $clog2(HALF);
  localparam logic [BCW-1:0]   BC_LAST    = BCW'(HALF - 1);
  localparam logic [3:0]       MATCH_LOCK = 4'(SYNC_COUNT);

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [WIDTH:0]   sr_q, sr_d;
    state_e           state_q, state_d;
    logic             off_q, off_d;
    logic [BCW-1:0]   bc_q, bc_d;
    logic [3:0]       match_q, match_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic [7:0]       fail_q, fail_d;

    logic [WIDTH-1:0] c0, c1, w;
    logic             boundary, c0_hit, c1_hit;

    always_comb begin
      sr_d     = {sr_q[WIDTH-2:0], bus.Q1[ch], bus.Q2[ch]};
      c0       = sr_q[WIDTH-1:0];
      c1       = sr_q[WIDTH:1];
      w        = off_q ? c1 : c0;
      boundary = (bc_q == BC_LAST);
      c0_hit   = (c0 == SYNC_PATTERN);
      c1_hit   = (c1 == SYNC_PATTERN);

      bc_d     = boundary ? '0 : bc_q + 1'b1;
      state_d  = state_q;
      off_d    = off_q;
      match_d  = match_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      fail_d   = fail_q;

      if (!bus.ENABLE) begin
        state_d = S_IDLE;
      end else if (bus.RESYNC[ch] && (state_q != S_IDLE)) begin
        // RESYNC outranks a coincident boundary: no word is delivered.
        state_d = S_HUNT;
      end else begin
        unique case (state_q)
          S_IDLE: state_d = S_HUNT;
          S_HUNT: begin
            if (c0_hit || c1_hit) begin
              // Even offset wins when both candidates match; restart the
              // boundary counter so the next full word lands on a boundary.
              off_d   = ~c0_hit;
              bc_d    = '0;
              match_d = 4'd1;
              state_d = (SYNC_COUNT == 1) ? S_LOCKED : S_VERIFY;
            end
          end
          S_VERIFY: begin
            if (boundary) begin
              if (w == SYNC_PATTERN) begin
                match_d = match_q + 4'd1;
                if (match_d == MATCH_LOCK) state_d = S_LOCKED;
              end else begin
                state_d = S_HUNT;
                if (fail_q != 8'hFF) fail_d = fail_q + 8'd1;
              end
            end
          end
          S_LOCKED: begin
            if (boundary) begin
              data_d  = w;
              valid_d = 1'b1;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end

      locked_d = (state_d == S_LOCKED);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        sr_q     <= '0;
        state_q  <= S_IDLE;
        off_q    <= 1'b0;
        bc_q     <= '0;
        match_q  <= '0;
        data_q   <= '0;
        valid_q  <= 1'b0;
        locked_q <= 1'b0;
        fail_q   <= '0;
      end else begin
        sr_q     <= sr_d;
        state_q  <= state_d;
        off_q    <= off_d;
        bc_q     <= bc_d;
        match_q  <= match_d;
        data_q   <= data_d;
        valid_q  <= valid_d;
        locked_q <= locked_d;
        fail_q   <= fail_d;
      end
    end

    assign bus.DATA[ch*WIDTH +: WIDTH] = data_q;
    assign bus.DATA_VALID[ch]          = valid_q;
    assign bus.LOCKED[ch]              = locked_q;
    assign bus.FAIL_CNT[ch*8 +: 8]     = fail_q;
  end

endmodule

// File: tb/tb_ddr_deser_align.sv
module tb_ddr_deser_align;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  ddr_deser_align_if #(.CHANNELS(2), .WIDTH(8)) bus ();

  ddr_deser_align #(
    .CHANNELS     (2),
    .WIDTH        (8),
    .SYNC_PATTERN (8'hA5),
    .SYNC_COUNT   (4)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic       bq0[$];
  logic       bq1[$];
  logic [7:0] exp0[$];
  logic [7:0] exp1[$];

  int pcnt = 0;
  int last_vt[2] = '{-1000, -1000};
  int gap[2] = '{0, 0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push_bit(input int ch, input logic b);
    if (ch == 0) bq0.push_back(b);
    else         bq1.push_back(b);
  endtask

  task automatic push_word(input int ch, input logic [7:0] w);
    for (int i = 7; i >= 0; i--) push_bit(ch, w[i]);
  endtask

  task automatic push_sync(input int ch, input int n);
    for (int i = 0; i < n; i++) push_word(ch, 8'hA5);
  endtask

  task automatic expect_word(input int ch, input logic [7:0] w);
    if (ch == 0) exp0.push_back(w);
    else         exp1.push_back(w);
  endtask

  // One clock of stimulus: two bits per channel, earlier bit on Q1.
  task automatic tick();
    logic [1:0] a, b;
    @(negedge clk);
    a = '0;
    b = '0;
    if (bq0.size() > 0) a[0] = bq0.pop_front();
    if (bq0.size() > 0) b[0] = bq0.pop_front();
    if (bq1.size() > 0) a[1] = bq1.pop_front();
    if (bq1.size() > 0) b[1] = bq1.pop_front();
    bus.Q1 = a;
    bus.Q2 = b;
  endtask

  task automatic flush();
    while (bq0.size() > 0 || bq1.size() > 0) tick();
  endtask

  // Let the last word's strobe out, then disable and clear the shift regs.
  task automatic quiesce();
    tick();
    tick();
    bus.ENABLE = 1'b0;
    repeat (8) tick();
    chk("locked_after_disable", 32'(bus.LOCKED), 32'h0);
  endtask

  // Scoreboard monitor: every DATA_VALID pops the channel's expected word.
  initial begin
    logic [7:0] got, want;
    forever begin
      @(posedge clk);
      #1;
      pcnt++;
      for (int c = 0; c < 2; c++) begin
        if (bus.DATA_VALID[c] === 1'b1) begin
          got = bus.DATA[c*8 +: 8];
          chk($sformatf("valid_while_locked_ch%0d", c), 32'(bus.LOCKED[c]), 32'h1);
          gap[c] = pcnt - last_vt[c];
          last_vt[c] = pcnt;
          chk($sformatf("valid_spacing_ge4_ch%0d", c), 32'(gap[c] >= 4), 32'h1);
          if ((c == 0 && exp0.size() == 0) || (c == 1 && exp1.size() == 0)) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_valid_ch%0d: got data 0x%0h, expected no strobe", c, got);
          end else begin
            want = (c == 0) ? exp0.pop_front() : exp1.pop_front();
            chk($sformatf("data_ch%0d", c), 32'(got), 32'(want));
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bus.ENABLE = 1'b0;
    bus.RESYNC = '0;
    bus.Q1     = '0;
    bus.Q2     = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_data",   32'(bus.DATA),       32'h0);
    chk("rst_valid",  32'(bus.DATA_VALID), 32'h0);
    chk("rst_locked", 32'(bus.LOCKED),     32'h0);
    chk("rst_fail",   32'(bus.FAIL_CNT),   32'h0);
    rst_n = 1'b1;
    tick();

    // Even offset on ch0, odd offset on ch1
    bus.ENABLE = 1'b1;
    push_word(0, 8'h00); push_sync(0, 4); push_word(0, 8'h3C); push_word(0, 8'h7E);
    push_bit(1, 1'b0);
    push_word(1, 8'h00); push_sync(1, 4); push_word(1, 8'h3C); push_word(1, 8'h7E);
    for (int c = 0; c < 2; c++) begin
      expect_word(c, 8'h3C);
      expect_word(c, 8'h7E);
    end
    repeat (21) tick();
    chk("t1_locked_before_4th", 32'(bus.LOCKED), 32'h0);
    tick();
    chk("t1_locked_even", 32'(bus.LOCKED), 32'h1);
    tick();
    chk("t1_locked_both", 32'(bus.LOCKED), 32'h3);
    flush();
    quiesce();
    chk("t1_gap_ch0", 32'(gap[0]), 32'd4);
    chk("t1_gap_ch1", 32'(gap[1]), 32'd4);
    chk("t1_data_hold", 32'(bus.DATA), 32'h7E7E);
    chk("t1_fail", 32'(bus.FAIL_CNT), 32'h0);

    // Verify failure then relock on ch0
    bus.ENABLE = 1'b1;
    push_word(0, 8'h00); push_sync(0, 2); push_word(0, 8'h00);
    push_sync(0, 4); push_word(0, 8'h3C);
    expect_word(0, 8'h3C);
    flush();
    quiesce();
    chk("t3_fail_ch0", 32'(bus.FAIL_CNT[7:0]), 32'd1);
    chk("t3_fail_ch1", 32'(bus.FAIL_CNT[15:8]), 32'd0);
    chk("t3_data_ch0", 32'(bus.DATA[7:0]), 32'h3C);

    // RESYNC on ch0 at the boundary of word 0x22
    bus.ENABLE = 1'b1;
    push_word(0, 8'h00); push_sync(0, 4); push_word(0, 8'h11); push_word(0, 8'h22);
    push_sync(0, 4); push_word(0, 8'h33);
    push_word(1, 8'h00); push_sync(1, 4); push_word(1, 8'h11); push_word(1, 8'h22);
    push_word(1, 8'h44); push_word(1, 8'h55); push_word(1, 8'h66);
    push_word(1, 8'h77); push_word(1, 8'h88);
    expect_word(0, 8'h11); expect_word(0, 8'h33);
    expect_word(1, 8'h11); expect_word(1, 8'h22); expect_word(1, 8'h44);
    expect_word(1, 8'h55); expect_word(1, 8'h66); expect_word(1, 8'h77);
    expect_word(1, 8'h88);
    repeat (29) tick();
    bus.RESYNC = 2'b01;
    tick();
    bus.RESYNC = 2'b00;
    chk("t4_locked_after_resync", 32'(bus.LOCKED), 32'h2);
    chk("t4_data_retained", 32'(bus.DATA[7:0]), 32'h11);
    repeat (16) tick();
    chk("t4_relocked", 32'(bus.LOCKED), 32'h3);
    flush();
    quiesce();
    chk("t4_fail_ch0_unchanged", 32'(bus.FAIL_CNT[7:0]), 32'd1);

    // Async reset while locked, mid-word
    bus.ENABLE = 1'b1;
    for (int c = 0; c < 2; c++) begin
      push_word(c, 8'h00); push_sync(c, 4); push_word(c, 8'h5A); push_word(c, 8'hC3);
      expect_word(c, 8'h5A);
    end
    repeat (26) tick();
    chk("t5_locked_pre_reset", 32'(bus.LOCKED), 32'h3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_async_data",   32'(bus.DATA),       32'h0);
    chk("t5_async_valid",  32'(bus.DATA_VALID), 32'h0);
    chk("t5_async_locked", 32'(bus.LOCKED),     32'h0);
    chk("t5_async_fail",   32'(bus.FAIL_CNT),   32'h0);
    bq0.delete();
    bq1.delete();
    bus.ENABLE = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      push_word(c, 8'h00); push_sync(c, 4); push_word(c, 8'h12); push_word(c, 8'h34);
    end
    flush();
    quiesce();
    chk("t5_disabled_no_data", 32'(bus.DATA), 32'h0);
    bus.ENABLE = 1'b1;
    for (int c = 0; c < 2; c++) begin
      push_word(c, 8'h00); push_sync(c, 4); push_word(c, 8'h99);
      expect_word(c, 8'h99);
    end
    flush();
    quiesce();
    chk("t5_relock_data", 32'(bus.DATA), 32'h9999);

    // FAIL_CNT saturation on ch1
    bus.ENABLE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_word(1, 8'hA5);
      push_word(1, 8'h00);
    end
    flush();
    tick();
    tick();
    chk("t6_fail_ch1_3", 32'(bus.FAIL_CNT[15:8]), 32'd3);
    for (int i = 0; i < 297; i++) begin
      push_word(1, 8'hA5);
      push_word(1, 8'h00);
    end
    flush();
    tick();
    tick();
    chk("t6_fail_ch1_sat", 32'(bus.FAIL_CNT[15:8]), 32'd255);
    chk("t6_fail_ch0", 32'(bus.FAIL_CNT[7:0]), 32'd0);
    quiesce();

    chk("exp_drained_ch0", 32'(exp0.size()), 32'd0);
    chk("exp_drained_ch1", 32'(exp1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
